rfblackwidow_fetch_queue: RTL

- Parametrised fetch/issue buffer placed between the instruction cache line extractor and the N-wide decoders.
- Replaces the fixed 3-slot, single-register fetch stage with a DEPTH-entry circular queue.
- Accepts FETCH_N instructions per push, truncates each push group after its first branch, and presents up to LANES instructions per cycle with their IPs.
- Supports partial consumption and redirect flush.

---
 rtl/rfblackwidow_fetch_queue.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/rfblackwidow_fetch_queue.sv
// rfblackwidow_fetch_queue
//
// Circular fetch/issue buffer that sits between the instruction cache line
// extractor and the N-wide decoders. Each fetch beat offers FETCH_N
// instructions. The beat is cut short after its first branch. Up to LANES
// instructions, each with its IP, are shown to the decoders every cycle.
// The decoders may consume only part of that group. A redirect flushes the
// queue.
//
// Ports:
//   clk_i, rst_i       clock, asynchronous active-low reset
//   flush_i/flush_ip_i redirect: drop all queued entries, restart fetch at flush_ip_i
//   fetch_req_o        room for a whole beat (pre-pop occupancy, masked by flush)
//   fetch_ip_o         IP of the next beat to fetch
//   fetch_vld_i        beat present on fetch_insn_i (lane 0 in the LSBs)
//   issue_vld_o        per-lane valid, contiguous from lane 0
//   issue_insn_o       issued instructions (NOP_INSN on invalid lanes)
//   issue_ip_o         IP of each issued instruction (0 on invalid lanes)
//   issue_cnt_i        number of instructions consumed this cycle
//   count_o            number of occupied entries
//   err_o              sticky flag: the consumer popped more than was valid
module rfblackwidow_fetch_queue #(
  parameter int unsigned       LANES      = 3,
  parameter int unsigned       DEPTH      = 8,
  parameter int unsigned       FETCH_N    = 4,
  parameter int unsigned       INSN_W     = 40,
  parameter int unsigned       IP_W       = 80,
  parameter int unsigned       INSN_BYTES = 5,
  parameter int unsigned       BR_BIT     = 7,
  parameter logic [INSN_W-1:0] NOP_INSN   = 40'h0,
  parameter logic [IP_W-1:0]   RESET_IP   = 80'h00FFFFFFFFFFFFFD0000
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic [IP_W-1:0]              flush_ip_i,
  output logic                         fetch_req_o,
  output logic [IP_W-1:0]              fetch_ip_o,
  input  logic                         fetch_vld_i,
  input  logic [FETCH_N*INSN_W-1:0]    fetch_insn_i,
  output logic [LANES-1:0]             issue_vld_o,
  output logic [LANES*INSN_W-1:0]      issue_insn_o,
  output logic [LANES*IP_W-1:0]        issue_ip_o,
  input  logic [$clog2(LANES+1)-1:0]   issue_cnt_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         err_o
);

  localparam int unsigned AW = $clog2(DEPTH);     // storage index width
  localparam int unsigned PW = AW + 1;            // pointer width, wraps mod 2*DEPTH
  localparam int unsigned CW = $clog2(DEPTH + 1); // occupancy width
  localparam int unsigned NW = $clog2(LANES + 1); // issue count width
  localparam int unsigned KW = $clog2(FETCH_N + 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [IP_W-1:0]   fetch_ip_q, fetch_ip_d;
  logic              err_q, err_d;

  // Storage is not reset: the issue view masks every entry that lies outside
  // [rd_ptr, wr_ptr).
  logic [INSN_W-1:0] mem_insn_q [DEPTH];
  logic [IP_W-1:0]   mem_ip_q   [DEPTH];

  // ---------------------------------------------------------------------------
  // Occupancy and fetch request
  // ---------------------------------------------------------------------------
  logic [PW-1:0] count;
  logic          push;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign count_o = CW'(count);

  // Uses the occupancy before this cycle's pop. Space freed by a same-cycle
  // pop is offered only on the following cycle.
  assign fetch_req_o = ((DEPTH - 32'(count)) >= FETCH_N) && !flush_i;
  assign push        = fetch_vld_i && fetch_req_o;

  // ---------------------------------------------------------------------------
  // Beat truncation: keep lanes up to and including the first branch
  // ---------------------------------------------------------------------------
  logic [KW-1:0] push_k;
  logic          br_found;

  always_comb begin
    push_k   = KW'(FETCH_N);
    br_found = 1'b0;
    for (int unsigned i = 0; i < FETCH_N; i++) begin
      if (!br_found && fetch_insn_i[i*INSN_W + BR_BIT]) begin
        push_k   = KW'(i + 1);
        br_found = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage write
  // ---------------------------------------------------------------------------
  logic [FETCH_N-1:0]  wr_en;
  logic [AW-1:0]       wr_idx [FETCH_N];
  logic [IP_W-1:0]     wr_ip  [FETCH_N];

  always_comb begin
    for (int unsigned i = 0; i < FETCH_N; i++) begin
      wr_en[i]  = push && (i < 32'(push_k));
      wr_idx[i] = AW'(wr_ptr_q + PW'(i));
      wr_ip[i]  = fetch_ip_q + IP_W'(i * INSN_BYTES);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < FETCH_N; i++) begin
      if (wr_en[i]) begin
        mem_insn_q[wr_idx[i]] <= fetch_insn_i[i*INSN_W +: INSN_W];
        mem_ip_q[wr_idx[i]]   <= wr_ip[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Issue view, combinational from registered state
  // ---------------------------------------------------------------------------
  logic [NW-1:0] vld_cnt;
  logic          br_seen;
  logic [AW-1:0] rd_idx;

  always_comb begin
    issue_vld_o  = '0;
    issue_insn_o = '0;
    issue_ip_o   = '0;
    vld_cnt      = '0;
    br_seen      = 1'b0;
    rd_idx       = '0;
    for (int unsigned j = 0; j < LANES; j++) begin
      rd_idx = AW'(rd_ptr_q + PW'(j));
      if ((j < 32'(count)) && !br_seen) begin
        issue_vld_o[j]                   = 1'b1;
        issue_insn_o[j*INSN_W +: INSN_W] = mem_insn_q[rd_idx];
        issue_ip_o[j*IP_W +: IP_W]       = mem_ip_q[rd_idx];
        vld_cnt                          = vld_cnt + NW'(1);
        // A branch closes the issue group; later lanes stay invalid.
        br_seen                          = mem_insn_q[rd_idx][BR_BIT];
      end else begin
        issue_insn_o[j*INSN_W +: INSN_W] = NOP_INSN;
        issue_ip_o[j*IP_W +: IP_W]       = '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pop with clamp
  // ---------------------------------------------------------------------------
  logic          over_pop;
  logic [NW-1:0] pop_cnt;

  assign over_pop = issue_cnt_i > vld_cnt;
  assign pop_cnt  = over_pop ? vld_cnt : issue_cnt_i;

  // ---------------------------------------------------------------------------
  // Next state. Flush wins over push and pop, and leaves err untouched.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fetch_ip_d = fetch_ip_q;
    err_d      = err_q;
    if (flush_i) begin
      rd_ptr_d   = wr_ptr_q;
      fetch_ip_d = flush_ip_i;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PW'(push_k);
        fetch_ip_d = fetch_ip_q + IP_W'(push_k * INSN_BYTES);
      end
      rd_ptr_d = rd_ptr_q + PW'(pop_cnt);
      if (over_pop) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fetch_ip_q <= RESET_IP;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fetch_ip_q <= fetch_ip_d;
      err_q      <= err_d;
    end
  end

  assign fetch_ip_o = fetch_ip_q;
  assign err_o      = err_q;

endmodule
